// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the EX-stage hazard sequencer and the pipeline/UART.
// The sequencer connects via the slave modport; the pipeline/UART side via master.
interface ex_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_RegWrite;
  logic             ex_MemRead;
  logic [4:0]       ex_rdist;
  logic             ex_UARTtoReg;
  logic             ex_RegtoUART;
  logic             mem_branch_taken;
  logic             uart_rx_valid;
  logic             uart_tx_ready;
  logic             perf_clr;
  logic             uart_rx_ack;
  logic             uart_tx_valid;
  logic             stall_if;
  logic             stall_id;
  logic             stall_ex;
  logic             bubble_ex;
  logic             flush_id;
  logic             flush_ex;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ex_RegWrite, ex_MemRead, ex_rdist,
           ex_UARTtoReg, ex_RegtoUART, mem_branch_taken, uart_rx_valid,
           uart_tx_ready, perf_clr,
    input  uart_rx_ack, uart_tx_valid, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, flush_ex, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ex_RegWrite, ex_MemRead, ex_rdist,
           ex_UARTtoReg, ex_RegtoUART, mem_branch_taken, uart_rx_valid,
           uart_tx_ready, perf_clr,
    output uart_rx_ack, uart_tx_valid, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, flush_ex, stall_cycles
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage sequencer: load-use bubbles, UART wait stalls and branch flushes,
// with Mealy outputs and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  ex_hazard_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {RUN, RX_WAIT, TX_WAIT, FLUSH} state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             rx_ack, tx_valid, st_if, st_id, st_ex, bubble, fl_id, fl_ex;

  assign load_use = bus.ex_MemRead && bus.ex_RegWrite && (bus.ex_rdist != 5'd0) &&
                    bus.id_valid &&
                    ((bus.id_rs == bus.ex_rdist) ||
                     (bus.id_uses_rt && (bus.id_rt == bus.ex_rdist)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (state_q != FLUSH && bus.mem_branch_taken) begin
      // A taken branch abandons any UART wait; the flushed instruction never completes.
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_RELOAD;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (bus.ex_UARTtoReg) begin
            if (!bus.uart_rx_valid) state_d = RX_WAIT;
          end else if (bus.ex_RegtoUART) begin
            if (!bus.uart_tx_ready) state_d = TX_WAIT;
          end
        end
        RX_WAIT: if (bus.uart_rx_valid) state_d = RUN;
        TX_WAIT: if (bus.uart_tx_ready) state_d = RUN;
        FLUSH: begin
          if (bus.mem_branch_taken) begin
            fcnt_d = FLUSH_RELOAD;
          end else if (fcnt_q <= 3'd1) begin
            state_d = RUN;
            fcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    rx_ack   = 1'b0;
    tx_valid = 1'b0;
    st_if    = 1'b0;
    st_id    = 1'b0;
    st_ex    = 1'b0;
    bubble   = 1'b0;
    fl_id    = 1'b0;
    fl_ex    = 1'b0;
    if (rstn) begin
      if (state_q == FLUSH || bus.mem_branch_taken) begin
        fl_id = 1'b1;
        fl_ex = 1'b1;
      end else begin
        case (state_q)
          RUN: begin
            if (bus.ex_UARTtoReg) begin
              if (bus.uart_rx_valid) rx_ack = 1'b1;
              else {st_if, st_id, st_ex} = 3'b111;
            end else if (bus.ex_RegtoUART) begin
              if (bus.uart_tx_ready) tx_valid = 1'b1;
              else {st_if, st_id, st_ex} = 3'b111;
            end else if (load_use) begin
              {st_if, st_id, bubble} = 3'b111;
            end
          end
          RX_WAIT: begin
            if (bus.uart_rx_valid) rx_ack = 1'b1;
            else {st_if, st_id, st_ex} = 3'b111;
          end
          TX_WAIT: begin
            if (bus.uart_tx_ready) tx_valid = 1'b1;
            else {st_if, st_id, st_ex} = 3'b111;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (bus.perf_clr) begin
      stall_cnt_q <= '0;
    end else if (st_if && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.uart_rx_ack   = rx_ack;
  assign bus.uart_tx_valid = tx_valid;
  assign bus.stall_if      = st_if;
  assign bus.stall_id      = st_id;
  assign bus.stall_ex      = st_ex;
  assign bus.bubble_ex     = bubble;
  assign bus.flush_id      = fl_id;
  assign bus.flush_ex      = fl_ex;
  assign bus.stall_cycles  = stall_cnt_q;

endmodule
